// File: rtl/led_pkg.sv
// Shared types and constants for the LED pattern sequencer and its tick generator.
package led_pkg;

   localparam int PERIOD_W = 16;

   typedef enum logic [1:0] {
      MODE_STATIC  = 2'd0,
      MODE_BLINK   = 2'd1,
      MODE_CHASE   = 2'd2,
      MODE_BREATHE = 2'd3
   } mode_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

endpackage

// File: rtl/led_tick_gen.sv
// Tick prescaler and step counter. Both counters sit at zero while run_i is low,
// so the first run cycle always starts a fresh step. step_strobe_o is
// combinational and marks the last cycle of each step.
module led_tick_gen
   import led_pkg::*;
#(
   parameter int PRESCALE = 10
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                run_i,
   input  logic [PERIOD_W-1:0] period_i,
   output logic                step_strobe_o
);

   localparam int            PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

   logic [PW-1:0]       presc_q, presc_d;
   logic [PERIOD_W-1:0] step_q, step_d;
   logic [PERIOD_W-1:0] last_step;
   logic                tick;

   // A period of zero behaves as a period of one.
   assign last_step     = (period_i == '0) ? '0 : period_i - PERIOD_W'(1);
   assign tick          = run_i && (presc_q == PRE_LAST);
   assign step_strobe_o = tick && (step_q == last_step);

   // Next-state for the prescaler and step counter.
   always_comb begin
      presc_d = presc_q;
      step_d  = step_q;
      if (!run_i) begin
         presc_d = '0;
         step_d  = '0;
      end else begin
         presc_d = tick ? '0 : presc_q + PW'(1);
         if (tick) begin
            step_d = step_strobe_o ? '0 : step_q + PERIOD_W'(1);
         end
      end
   end

   // Counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q <= '0;
         step_q  <= '0;
      end else begin
         presc_q <= presc_d;
         step_q  <= step_d;
      end
   end

endmodule

// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: static, blink, bounce-chase and breathe patterns on a
// programmable step period. Config written while running is held in a shadow
// copy and applied at the next step boundary.
// Optional build macro LED_PAT_GAMMA_EN: squares the breathe ramp for the duty
// output, adding one register stage of duty latency in BREATHE.
//
// state   | meaning
// ST_IDLE | outputs forced low, cfg_wr writes the active config directly
// ST_RUN  | pattern running, cfg_wr goes to the shadow until the next boundary
module led_pattern_sequencer
   import led_pkg::*;
#(
   parameter int NUM_LEDS       = 4,
   parameter int PWM_RESOLUTION = 8,
   parameter int CLK_FREQ_HZ    = 100_000_000,
   parameter int TICK_HZ        = 1000
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      enable,
   input  logic                      cfg_wr,
   input  logic [1:0]                cfg_mode,
   input  logic [NUM_LEDS-1:0]       cfg_pattern,
   input  logic [PWM_RESOLUTION-1:0] cfg_bright,
   input  logic [PERIOD_W-1:0]       cfg_period,
   output logic [NUM_LEDS-1:0]       led_ctrl,
   output logic [PWM_RESOLUTION-1:0] pwm_duty,
   output logic                      step_strobe,
   output logic                      cfg_pending,
   output logic                      busy
);

   localparam int                        PRESCALE = CLK_FREQ_HZ / TICK_HZ;
   localparam int                        POS_W    = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
   localparam logic [POS_W-1:0]          POS_MAX  = POS_W'(NUM_LEDS - 1);
   localparam logic [PWM_RESOLUTION-1:0] RAMP_MAX = '1;

   state_e                    state_q, state_d;
   mode_e                     mode_q, mode_d, sh_mode_q, sh_mode_d;
   logic [NUM_LEDS-1:0]       pat_q, pat_d, sh_pat_q, sh_pat_d;
   logic [PWM_RESOLUTION-1:0] bright_q, bright_d, sh_bright_q, sh_bright_d;
   logic [PERIOD_W-1:0]       period_q, period_d, sh_period_q, sh_period_d;
   logic                      pend_q, pend_d;
   logic [POS_W-1:0]          pos_q, pos_d;
   logic [PWM_RESOLUTION-1:0] ramp_q, ramp_d;
   logic                      up_q, up_d;
   logic                      phase_q, phase_d;
   logic [NUM_LEDS-1:0]       led_q, led_d;
   logic [PWM_RESOLUTION-1:0] duty_q, duty_d;
   logic                      restart, emit;
   logic                      run;
   logic                      strobe;

   assign run = (state_q == ST_RUN);

   led_tick_gen #(
      .PRESCALE (PRESCALE)
   ) u_tick (
      .clk           (clk),
      .rst_n         (rst_n),
      .run_i         (run),
      .period_i      (period_q),
      .step_strobe_o (strobe)
   );

   // FSM, config capture and pattern-state next values; outputs are derived from
   // the next pattern state so they change the cycle after a boundary.
   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      pat_d       = pat_q;
      bright_d    = bright_q;
      period_d    = period_q;
      sh_mode_d   = sh_mode_q;
      sh_pat_d    = sh_pat_q;
      sh_bright_d = sh_bright_q;
      sh_period_d = sh_period_q;
      pend_d      = pend_q;
      pos_d       = pos_q;
      ramp_d      = ramp_q;
      up_d        = up_q;
      phase_d     = phase_q;
      led_d       = led_q;
      duty_d      = duty_q;
      restart     = 1'b0;
      emit        = 1'b0;

      case (state_q)
         ST_IDLE: begin
            led_d  = '0;
            duty_d = '0;
            pend_d = 1'b0;
            if (cfg_wr) begin
               mode_d   = mode_e'(cfg_mode);
               pat_d    = cfg_pattern;
               bright_d = cfg_bright;
               period_d = cfg_period;
            end
            sh_mode_d   = mode_d;
            sh_pat_d    = pat_d;
            sh_bright_d = bright_d;
            sh_period_d = period_d;
            if (enable) begin
               state_d = ST_RUN;
               restart = 1'b1;
               emit    = 1'b1;
            end
         end
         ST_RUN: begin
            if (!enable) begin
               state_d     = ST_IDLE;
               led_d       = '0;
               duty_d      = '0;
               pend_d      = 1'b0;
               sh_mode_d   = mode_q;
               sh_pat_d    = pat_q;
               sh_bright_d = bright_q;
               sh_period_d = period_q;
            end else begin
               emit = 1'b1;
               if (strobe) begin
                  pend_d = 1'b0;
                  if (cfg_wr) begin
                     // A write landing on the boundary itself takes effect right away.
                     mode_d   = mode_e'(cfg_mode);
                     pat_d    = cfg_pattern;
                     bright_d = cfg_bright;
                     period_d = cfg_period;
                     restart  = 1'b1;
                  end else if (pend_q) begin
                     mode_d   = sh_mode_q;
                     pat_d    = sh_pat_q;
                     bright_d = sh_bright_q;
                     period_d = sh_period_q;
                     restart  = 1'b1;
                  end else begin
                     case (mode_q)
                        MODE_BLINK: phase_d = ~phase_q;
                        MODE_CHASE: begin
                           if (NUM_LEDS > 1) begin
                              if (up_q) begin
                                 if (pos_q == POS_MAX) begin
                                    pos_d = pos_q - POS_W'(1);
                                    up_d  = 1'b0;
                                 end else begin
                                    pos_d = pos_q + POS_W'(1);
                                 end
                              end else begin
                                 if (pos_q == '0) begin
                                    pos_d = pos_q + POS_W'(1);
                                    up_d  = 1'b1;
                                 end else begin
                                    pos_d = pos_q - POS_W'(1);
                                 end
                              end
                           end
                        end
                        MODE_BREATHE: begin
                           if (up_q) begin
                              if (ramp_q == RAMP_MAX) begin
                                 ramp_d = ramp_q - PWM_RESOLUTION'(1);
                                 up_d   = 1'b0;
                              end else begin
                                 ramp_d = ramp_q + PWM_RESOLUTION'(1);
                              end
                           end else begin
                              if (ramp_q == '0) begin
                                 ramp_d = ramp_q + PWM_RESOLUTION'(1);
                                 up_d   = 1'b1;
                              end else begin
                                 ramp_d = ramp_q - PWM_RESOLUTION'(1);
                              end
                           end
                        end
                        default: ;
                     endcase
                  end
               end else if (cfg_wr) begin
                  sh_mode_d   = mode_e'(cfg_mode);
                  sh_pat_d    = cfg_pattern;
                  sh_bright_d = cfg_bright;
                  sh_period_d = cfg_period;
                  pend_d      = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (restart) begin
         pos_d   = '0;
         ramp_d  = '0;
         up_d    = 1'b1;
         phase_d = 1'b1;
      end

      if (emit) begin
         duty_d = bright_d;
         case (mode_d)
            MODE_STATIC:  led_d = pat_d;
            MODE_BLINK:   led_d = phase_d ? pat_d : '0;
            MODE_CHASE:   led_d = pat_d & (NUM_LEDS'(1) << pos_d);
            MODE_BREATHE: begin
               led_d  = pat_d;
               duty_d = ramp_d;
            end
            default:      led_d = '0;
         endcase
      end
   end

   // State, config, shadow and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         mode_q      <= MODE_STATIC;
         pat_q       <= '0;
         bright_q    <= '0;
         period_q    <= PERIOD_W'(1);
         sh_mode_q   <= MODE_STATIC;
         sh_pat_q    <= '0;
         sh_bright_q <= '0;
         sh_period_q <= PERIOD_W'(1);
         pend_q      <= 1'b0;
         pos_q       <= '0;
         ramp_q      <= '0;
         up_q        <= 1'b1;
         phase_q     <= 1'b1;
         led_q       <= '0;
         duty_q      <= '0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         pat_q       <= pat_d;
         bright_q    <= bright_d;
         period_q    <= period_d;
         sh_mode_q   <= sh_mode_d;
         sh_pat_q    <= sh_pat_d;
         sh_bright_q <= sh_bright_d;
         sh_period_q <= sh_period_d;
         pend_q      <= pend_d;
         pos_q       <= pos_d;
         ramp_q      <= ramp_d;
         up_q        <= up_d;
         phase_q     <= phase_d;
         led_q       <= led_d;
         duty_q      <= duty_d;
      end
   end

`ifdef LED_PAT_GAMMA_EN
   logic [2*PWM_RESOLUTION-1:0] sq;
   logic [PWM_RESOLUTION-1:0]   gam_q;
   logic                        brth_q, gsel_q;

   assign sq = {{PWM_RESOLUTION{1'b0}}, duty_q} * {{PWM_RESOLUTION{1'b0}}, duty_q};

   // Gamma stage: brth_q marks duty_q as a breathe ramp value, gsel_q follows gam_q.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gam_q  <= '0;
         brth_q <= 1'b0;
         gsel_q <= 1'b0;
      end else begin
         gam_q  <= sq[2*PWM_RESOLUTION-1:PWM_RESOLUTION];
         brth_q <= (state_d == ST_RUN) && (mode_d == MODE_BREATHE);
         gsel_q <= brth_q;
      end
   end

   assign pwm_duty = gsel_q ? gam_q : duty_q;
`else
   assign pwm_duty = duty_q;
`endif

   assign led_ctrl    = led_q;
   assign step_strobe = strobe;
   assign cfg_pending = pend_q;
   assign busy        = run;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Bench for led_pattern_sequencer with PRESCALE = 10 and four LEDs. The reference
// model works at step granularity: it remembers when the current config segment
// started and derives the step index, blink phase, bounce position and ramp value
// arithmetically from elapsed cycles.
module tb_led_pattern_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic        cfg_wr = 1'b0;
   logic [1:0]  cfg_mode = 2'd0;
   logic [3:0]  cfg_pattern = 4'd0;
   logic [7:0]  cfg_bright = 8'd0;
   logic [15:0] cfg_period = 16'd0;
   logic [3:0]  led_ctrl;
   logic [7:0]  pwm_duty;
   logic        step_strobe, cfg_pending, busy;

   int checks = 0;
   int errors = 0;
   int t = 0;
   string tag = "reset";

   bit m_run, m_pend;
   int m_t0;
   int a_mode, a_pat, a_bright, a_period;
   int s_mode, s_pat, s_bright, s_period;

   always #5 clk = ~clk;

   led_pattern_sequencer #(
      .NUM_LEDS       (4),
      .PWM_RESOLUTION (8),
      .CLK_FREQ_HZ    (1000),
      .TICK_HZ        (100)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .cfg_wr      (cfg_wr),
      .cfg_mode    (cfg_mode),
      .cfg_pattern (cfg_pattern),
      .cfg_bright  (cfg_bright),
      .cfg_period  (cfg_period),
      .led_ctrl    (led_ctrl),
      .pwm_duty    (pwm_duty),
      .step_strobe (step_strobe),
      .cfg_pending (cfg_pending),
      .busy        (busy)
   );

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s/%s cycle %0d: observed %0h expected %0h", tag, name, t, obs, exp);
      end
   endtask

   function automatic int step_len();
      return 10 * ((a_period == 0) ? 1 : a_period);
   endfunction

   function automatic bit m_bnd();
      return m_run && (((t - m_t0 + 1) % step_len()) == 0);
   endfunction

   task automatic model_reset();
      m_run = 0; m_pend = 0; m_t0 = 0;
      a_mode = 0; a_pat = 0; a_bright = 0; a_period = 1;
      s_mode = 0; s_pat = 0; s_bright = 0; s_period = 1;
   endtask

   task automatic load_inputs_active();
      a_mode = int'(cfg_mode); a_pat = int'(cfg_pattern);
      a_bright = int'(cfg_bright); a_period = int'(cfg_period);
   endtask

   task automatic check_all();
      int k, m, pos;
      logic [3:0] e_led;
      logic [7:0] e_duty;
      logic       e_str;
      e_led = 4'd0; e_duty = 8'd0; e_str = 1'b0;
      if (m_run) begin
         k      = (t - m_t0) / step_len();
         e_str  = m_bnd();
         e_duty = 8'(a_bright);
         case (a_mode)
            1: e_led = (k % 2 == 0) ? 4'(a_pat) : 4'd0;
            2: begin
               m     = k % 6;
               pos   = (m < 4) ? m : 6 - m;
               e_led = 4'(a_pat) & 4'(1 << pos);
            end
            3: begin
               m      = k % 510;
               e_duty = 8'((m <= 255) ? m : 510 - m);
               e_led  = 4'(a_pat);
            end
            default: e_led = 4'(a_pat);
         endcase
      end
      chk("led_ctrl", 32'(led_ctrl), 32'(e_led));
      chk("pwm_duty", 32'(pwm_duty), 32'(e_duty));
      chk("step_strobe", 32'(step_strobe), 32'(e_str));
      chk("busy", 32'(busy), 32'(m_run));
      chk("cfg_pending", 32'(cfg_pending), 32'(m_pend));
   endtask

   // One clock with the currently driven inputs, then compare the new cycle.
   task automatic step();
      bit bnd;
      bnd = m_bnd();
      if (!m_run) begin
         if (cfg_wr) load_inputs_active();
         if (enable) begin m_run = 1; m_t0 = t + 1; end
      end else if (!enable) begin
         m_run = 0; m_pend = 0;
      end else if (bnd) begin
         if (cfg_wr) begin
            load_inputs_active(); m_t0 = t + 1;
         end else if (m_pend) begin
            a_mode = s_mode; a_pat = s_pat; a_bright = s_bright; a_period = s_period;
            m_t0 = t + 1;
         end
         m_pend = 0;
      end else if (cfg_wr) begin
         s_mode = int'(cfg_mode); s_pat = int'(cfg_pattern);
         s_bright = int'(cfg_bright); s_period = int'(cfg_period);
         m_pend = 1;
      end
      @(posedge clk); #1;
      t++;
      check_all();
   endtask

   task automatic run_n(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic write_cfg(input logic [1:0] md, input logic [3:0] pat,
                            input logic [7:0] br, input logic [15:0] per);
      cfg_mode = md; cfg_pattern = pat; cfg_bright = br; cfg_period = per;
      cfg_wr = 1'b1;
      step();
      cfg_wr = 1'b0;
   endtask

   initial begin
      model_reset();
      #2;
      check_all();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      check_all();

      tag = "blink";
      write_cfg(2'd1, 4'b1010, 8'($urandom), 16'd2);
      enable = 1'b1;
      run_n(90);

      tag = "reset_in_run";
      enable = 1'b0;
      step();
      write_cfg(2'd1, 4'b1111, 8'($urandom_range(1, 255)), 16'd1);
      enable = 1'b1;
      run_n(15);
      @(negedge clk);
      rst_n = 1'b0;
      enable = 1'b0;
      #1;
      model_reset();
      check_all();
      repeat (3) begin @(posedge clk); #1; t++; end
      rst_n = 1'b1;
      run_n(3);

      tag = "chase";
      write_cfg(2'd2, 4'hF, 8'($urandom), 16'd1);
      enable = 1'b1;
      run_n(80);

      tag = "breathe";
      enable = 1'b0;
      step();
      write_cfg(2'd3, 4'($urandom), 8'($urandom), 16'd1);
      enable = 1'b1;
      run_n(5200);

      tag = "pending";
      enable = 1'b0;
      step();
      write_cfg(2'd0, 4'b0011, 8'($urandom), 16'd2);
      enable = 1'b1;
      run_n(5);
      write_cfg(2'd2, 4'hF, 8'($urandom), 16'd1);
      run_n(60);

      tag = "coincident";
      for (int n = 0; n < 200 && !m_bnd(); n++) step();
      chk("strobe_reached", 32'(step_strobe), 32'd1);
      write_cfg(2'd1, 4'b0110, 8'($urandom), 16'd0);
      run_n(40);

      tag = "last_write";
      run_n(3);
      write_cfg(2'd3, 4'b1111, 8'($urandom), 16'd1);
      run_n(2);
      write_cfg(2'd0, 4'b1001, 8'($urandom), 16'd3);
      run_n(40);

      tag = "random";
      for (int i = 0; i < 3000; i++) begin
         enable = ($urandom_range(0, 99) < 97);
         cfg_wr = ($urandom_range(0, 29) == 0);
         if (cfg_wr) begin
            cfg_mode    = 2'($urandom_range(0, 3));
            cfg_pattern = 4'($urandom);
            cfg_bright  = 8'($urandom);
            cfg_period  = 16'($urandom_range(0, 3));
         end
         step();
      end
      cfg_wr = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
